// File: rtl/parallel_axis_vip_pkg.sv
// alpaca_dtypes_pkg: shared sample types for the parallel-sample AXI-Stream path.
//   cx_t        : packed complex sample {re, im}, each signed 16-bit (re in the upper half)
//   SAMP_W      : width of one real/imag component
//   CX_W        : width of one complex sample
//   beat_width(): packed beat width for a given samples-per-clock count
package alpaca_dtypes_pkg;

   localparam int SAMP_W = 16;
   localparam int CX_W   = 2 * SAMP_W;

   typedef struct packed {
      logic signed [SAMP_W-1:0] re;
      logic signed [SAMP_W-1:0] im;
   } cx_t;

   function automatic int beat_width(input int samp_per_clk);
      return samp_per_clk * CX_W;
   endfunction

endpackage

// File: rtl/parallel_axis_vip_if.sv
// alpaca_data_pkt_axis: AXI-Stream carrying SAMP_PER_CLK samples of type dtype per beat.
//   tdata  : packed packet, sample k in bits [k*$bits(dtype) +: $bits(dtype)]
//   tvalid : beat valid (MST -> SLV)
//   tready : sink ready (SLV -> MST)
//   tuser  : TUSER-bit side band (MST -> SLV)
//   tlast  : end of packet (MST -> SLV)
interface alpaca_data_pkt_axis
   import alpaca_dtypes_pkg::*;
#(
   parameter type dtype        = cx_t,
   parameter int  SAMP_PER_CLK = 2,
   parameter int  TUSER        = 1
) ();

   typedef dtype [SAMP_PER_CLK-1:0] pkt_t;

   pkt_t             tdata;
   logic             tvalid;
   logic             tready;
   logic [TUSER-1:0] tuser;
   logic             tlast;

   modport MST (output tdata, output tvalid, output tuser, output tlast, input tready);
   modport SLV (input tdata, input tvalid, input tuser, input tlast, output tready);

endinterface

// File: rtl/parallel_axis_vip_capture_ram.sv
// vip_capture_ram: DEPTH x WIDTH capture array with one synchronous write port.
//   clk   : write clock (rising edge)
//   we    : write enable
//   addr  : write address
//   wdata : write data
//   raddr : asynchronous inspection read address
//   rdata : word at raddr
// The array is named ram so it can be reached hierarchically for offline analysis.
module vip_capture_ram #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] ram [DEPTH];

   // No reset on the array: captured contents survive a pointer reset.
   always_ff @(posedge clk) begin
      if (we) begin
         ram[addr] <= wdata;
      end
   end

   assign rdata = ram[raddr];

endmodule

// File: rtl/parallel_axis_vip.sv
// parallel_axis_vip: captures accepted AXI-Stream beats into a DEPTH-word RAM, then stops.
//   clk    : clock, rising edge
//   rst    : asynchronous reset, active low
//   en     : capture enable
//   s_axis : slave side of alpaca_data_pkt_axis (tuser/tlast accepted, not stored)
//   full   : high once DEPTH beats have been written; held until reset
// DEPTH must be a power of two and at least 2.
module parallel_axis_vip
   import alpaca_dtypes_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   alpaca_data_pkt_axis.SLV    s_axis,
   output logic                full
);

   localparam int AW     = $clog2(DEPTH);
   localparam int BEAT_W = beat_width(s_axis.SAMP_PER_CLK);

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic              full_q, full_d;
   logic              accept;
   logic [BEAT_W-1:0] unused_rdata;
   logic              unused_side;

   // rst is folded in so tready is low for the whole time reset is asserted.
   assign s_axis.tready = en & ~full_q & rst;
   assign accept        = s_axis.tvalid & s_axis.tready;
   assign full          = full_q;
   assign unused_side   = ^{s_axis.tuser, s_axis.tlast};

   // The pointer parks on the last address; full alone blocks further writes.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      full_d   = full_q;
      if (accept) begin
         if (wr_ptr_q == AW'(DEPTH - 1)) begin
            full_d = 1'b1;
         end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         full_q   <= full_d;
      end
   end

   vip_capture_ram #(
      .DEPTH (DEPTH),
      .WIDTH (BEAT_W)
   ) u_ram (
      .clk   (clk),
      .we    (accept),
      .addr  (wr_ptr_q),
      .wdata (s_axis.tdata),
      .raddr (wr_ptr_q),
      .rdata (unused_rdata)
   );

endmodule

// File: tb/tb_parallel_axis_vip.sv
// Directed bench for parallel_axis_vip with SAMP_PER_CLK=2, DEPTH=64.
module tb_parallel_axis_vip;
   import alpaca_dtypes_pkg::*;

   localparam int DEPTH = 64;

   logic clk = 1'b0;
   logic rst;
   logic en;
   logic full;
   cx_t  s_a;
   cx_t  s_b;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   alpaca_data_pkt_axis #(.dtype(cx_t), .SAMP_PER_CLK(2), .TUSER(1)) axis ();

   parallel_axis_vip #(.DEPTH(DEPTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .s_axis (axis),
      .full   (full)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Beat n of the fill pattern: sample k = {re=2n+k, im=-(2n+k)}, packed {s1, s0}.
   function automatic logic [63:0] fill_beat(input int n);
      logic [15:0] r0, i0, r1, i1;
      r0 = 16'(2 * n);
      i0 = 16'(-(2 * n));
      r1 = 16'(2 * n + 1);
      i1 = 16'(-(2 * n + 1));
      return {r1, i1, r0, i0};
   endfunction

   function automatic logic [63:0] pat_g(input int m);
      return {16'(16'h1000 + m), 16'(16'h2000 + m), 16'(16'h3000 + m), 16'(16'h4000 + m)};
   endfunction

   function automatic logic [63:0] pat_d(input int m);
      return {16'(16'h5000 + m), 16'(16'h6000 + m), 16'(16'h7000 + m), 16'(16'h0100 + m)};
   endfunction

   initial begin
      rst         = 1'b0;
      en          = 1'b0;
      axis.tvalid = 1'b0;
      axis.tdata  = '0;
      axis.tuser  = '0;
      axis.tlast  = 1'b0;
      tick();
      tick();

      // reset state
      chk("rst_full",   64'(full), 64'd0);
      chk("rst_tready", 64'(axis.tready), 64'd0);
      chk("rst_ptr",    64'(dut.wr_ptr_q), 64'd0);
      en          = 1'b1;
      axis.tvalid = 1'b1;
      #1;
      chk("rst_tready_en", 64'(axis.tready), 64'd0);
      axis.tvalid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("tready_release", 64'(axis.tready), 64'd1);

      // fill, valid every cycle
      for (int n = 0; n < 64; n++) begin
         axis.tdata  = fill_beat(n);
         axis.tvalid = 1'b1;
         axis.tlast  = (n == 63);
         axis.tuser  = 1'(n & 1);
         tick();
         if (n == 62) chk("fill_full_early", 64'(full), 64'd0);
      end
      chk("fill_full",   64'(full), 64'd1);
      chk("fill_tready", 64'(axis.tready), 64'd0);
      chk("fill_ptr",    64'(dut.wr_ptr_q), 64'd63);
      chk("fill_ram0",   dut.u_ram.ram[0],  64'h0001_FFFF_0000_0000);
      chk("fill_ram5",   dut.u_ram.ram[5],  64'h000B_FFF5_000A_FFF6);
      chk("fill_ram63",  dut.u_ram.ram[63], 64'h007F_FF81_007E_FF82);

      // keep driving after full
      for (int i = 0; i < 100; i++) begin
         axis.tdata = 64'hDEAD_0000_0000_0000 | 64'(i);
         tick();
         chk("hold_full",   64'(full), 64'd1);
         chk("hold_tready", 64'(axis.tready), 64'd0);
      end
      chk("hold_ram0",  dut.u_ram.ram[0],  64'h0001_FFFF_0000_0000);
      chk("hold_ram63", dut.u_ram.ram[63], 64'h007F_FF81_007E_FF82);
      chk("hold_ptr",   64'(dut.wr_ptr_q), 64'd63);

      // asynchronous reset between edges
      #2;
      rst = 1'b0;
      #1;
      chk("arst_full",   64'(full), 64'd0);
      chk("arst_tready", 64'(axis.tready), 64'd0);
      chk("arst_ptr",    64'(dut.wr_ptr_q), 64'd0);
      tick();
      axis.tvalid = 1'b0;
      rst = 1'b1;

      // en low blocks capture
      en          = 1'b0;
      axis.tvalid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         axis.tdata = 64'hBAD0_0000_0000_0000 + 64'(i);
         tick();
      end
      chk("enlow_tready", 64'(axis.tready), 64'd0);
      chk("enlow_ptr",    64'(dut.wr_ptr_q), 64'd0);
      chk("enlow_ram0",   dut.u_ram.ram[0], 64'h0001_FFFF_0000_0000);
      chk("enlow_ram1",   dut.u_ram.ram[1], 64'h0003_FFFD_0002_FFFE);
      en         = 1'b1;
      axis.tdata = 64'hC0DE_0001_C0DE_0002;
      tick();
      axis.tvalid = 1'b0;
      chk("en_first_ram0", dut.u_ram.ram[0], 64'hC0DE_0001_C0DE_0002);
      chk("en_first_ptr",  64'(dut.wr_ptr_q), 64'd1);

      // gapped valid, junk data on idle cycles
      rst = 1'b0;
      #1;
      rst = 1'b1;
      for (int c = 0; c < 128; c++) begin
         axis.tvalid = ((c % 2) == 0);
         axis.tdata  = ((c % 2) == 0) ? pat_g(c / 2) : (64'hEEEE_EEEE_EEEE_0000 | 64'(c));
         tick();
         if (c == 125) chk("gap_full_early", 64'(full), 64'd0);
      end
      axis.tvalid = 1'b0;
      chk("gap_full", 64'(full), 64'd1);
      for (int a = 0; a < DEPTH; a++) begin
         chk($sformatf("gap_ram%0d", a), dut.u_ram.ram[a], pat_g(a));
      end

      // reset in the middle of a capture
      rst = 1'b0;
      #1;
      rst = 1'b1;
      axis.tvalid = 1'b1;
      for (int m = 0; m < 30; m++) begin
         axis.tdata = 64'hAAAA_0000_0000_0000 | 64'(m);
         tick();
      end
      chk("mid_ptr30", 64'(dut.wr_ptr_q), 64'd30);
      rst = 1'b0;
      #1;
      chk("mid_rst_full",   64'(full), 64'd0);
      chk("mid_rst_tready", 64'(axis.tready), 64'd0);
      tick();
      tick();
      chk("mid_rst_ptr",     64'(dut.wr_ptr_q), 64'd0);
      chk("mid_rst_tready2", 64'(axis.tready), 64'd0);
      axis.tvalid = 1'b0;
      rst = 1'b1;
      for (int m = 0; m < 64; m++) begin
         axis.tdata  = pat_d(m);
         axis.tvalid = 1'b1;
         tick();
         if (m == 0)  chk("mid_first_ram0", dut.u_ram.ram[0], pat_d(0));
         if (m == 62) chk("mid_full_early", 64'(full), 64'd0);
      end
      axis.tvalid = 1'b0;
      chk("mid_full",   64'(full), 64'd1);
      chk("mid_ram29",  dut.u_ram.ram[29], pat_d(29));
      chk("mid_ram63",  dut.u_ram.ram[63], pat_d(63));

      // sign / packing
      rst = 1'b0;
      #1;
      rst = 1'b1;
      s_a.re = 16'h8000;
      s_a.im = 16'h7FFF;
      s_b.re = 16'h1234;
      s_b.im = 16'hABCD;
      axis.tdata  = {s_a, s_a};
      axis.tvalid = 1'b1;
      tick();
      axis.tdata = {s_b, s_a};
      tick();
      axis.tvalid = 1'b0;
      chk("pack_ram0", dut.u_ram.ram[0], 64'h8000_7FFF_8000_7FFF);
      chk("pack_ram1", dut.u_ram.ram[1], 64'h1234_ABCD_8000_7FFF);
      chk("pack_ptr",  64'(dut.wr_ptr_q), 64'd2);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
